sdram_req_adapter: RTL and testbench

SDRAM_REQ_ADAPTER -- requirements
Module: sdram_req_adapter

---
 rtl/sdram_pkg.sv | 19 +
 rtl/sdram_req_adapter_if.sv | 27 ++
 rtl/sdram_req_adapter.sv | 118 +++++++++++
 tb/tb_sdram_req_adapter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: controller command encoding and address field widths.
package sdram_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } cmd_e;

    localparam int BankWidth      = 2;
    localparam int RowWidth       = 13;
    localparam int ColWidth       = 10;
    localparam int SdramAddrWidth = BankWidth + RowWidth + ColWidth;

    function automatic cmd_e cmd_for(input logic is_write);
        return is_write ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/sdram_req_adapter_if.sv
// Client-side request/response handshake of the SDRAM request adapter.
interface sdram_req_adapter_if #(
    parameter int AddrWidth = 25,
    parameter int DataWidth = 16
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_write_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_write_o;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic                 rsp_err_o;

    // The client drives requests and consumes responses.
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/sdram_req_adapter.sv
// Turns one client request at a time into a held controller command, waits for
// the matching completion pulse (or times out) and returns a single response.
module sdram_req_adapter
    import sdram_pkg::*;
#(
    parameter int TimeoutCycles = 4096,
    parameter int AddrWidth     = SdramAddrWidth,
    parameter int DataWidth     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sdram_req_adapter_if.slave   bus,
    output logic [1:0]           ctrl_command_o,
    output logic [AddrWidth-1:0] ctrl_addr_o,
    output logic [DataWidth-1:0] ctrl_wdata_o,
    input  logic [DataWidth-1:0] ctrl_rdata_i,
    input  logic                 ctrl_read_valid_i,
    input  logic                 ctrl_write_done_i
);

    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WR,
        WAIT_RD,
        RESP
    } state_e;

    state_e               state;
    cmd_e                 cmd;
    logic [CntWidth-1:0]  wait_cnt;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 req_ready;
    logic                 rsp_valid;
    logic                 rsp_write;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_err;

    assign ctrl_command_o  = cmd;
    assign ctrl_addr_o     = addr_q;
    assign ctrl_wdata_o    = wdata_q;
    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_write_o = rsp_write;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;

    // Completion is checked before the timeout so a pulse in the final wait
    // cycle still yields a clean response; the counter therefore never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cmd       <= CMD_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i && req_ready) begin
                        addr_q    <= bus.req_addr_i;
                        wdata_q   <= bus.req_wdata_i;
                        wait_cnt  <= '0;
                        cmd       <= cmd_for(bus.req_write_i);
                        req_ready <= 1'b0;
                        state     <= bus.req_write_i ? WAIT_WR : WAIT_RD;
                    end
                end
                WAIT_WR: begin
                    if (ctrl_write_done_i || wait_cnt == CntLast) begin
                        state     <= RESP;
                        cmd       <= CMD_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= !ctrl_write_done_i;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_RD: begin
                    if (ctrl_read_valid_i || wait_cnt == CntLast) begin
                        state     <= RESP;
                        cmd       <= CMD_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= ctrl_read_valid_i ? ctrl_rdata_i : '0;
                        rsp_err   <= !ctrl_read_valid_i;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd       <= CMD_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_adapter.sv
// Randomised self-checking bench for sdram_req_adapter against a per-transaction
// reference model (command length, response fields, handshake timing).
module tb_sdram_req_adapter;
    import sdram_pkg::*;

    localparam int T  = 16;
    localparam int AW = 25;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    ctrl_command;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_wdata;
    logic [DW-1:0] ctrl_rdata;
    logic          ctrl_read_valid;
    logic          ctrl_write_done;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    sdram_req_adapter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    sdram_req_adapter #(.TimeoutCycles(T), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus               (bus),
        .ctrl_command_o    (ctrl_command),
        .ctrl_addr_o       (ctrl_addr),
        .ctrl_wdata_o      (ctrl_wdata),
        .ctrl_rdata_i      (ctrl_rdata),
        .ctrl_read_valid_i (ctrl_read_valid),
        .ctrl_write_done_i (ctrl_write_done)
    );

    // Model: completion in wait cycle d (1-based) ends the wait after d cycles
    // if d <= T, otherwise the command times out after exactly T cycles.
    task automatic run_txn(input bit is_write, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] rdata,
                           input int delay, input int hold, input bit stray);
        bit            timed_out;
        int            waits;
        logic [1:0]    exp_cmd;
        logic [DW-1:0] exp_rdata;
        timed_out = delay > T;
        waits     = timed_out ? T : delay;
        exp_cmd   = is_write ? 2'd1 : 2'd2;
        exp_rdata = (is_write || timed_out) ? '0 : rdata;

        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_before_accept: got %b expected 1", bus.req_ready_o);
        end
        bus.req_valid_i = 1'b1;
        bus.req_write_i = is_write;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = data;
        @(negedge clk);
        for (int i = 1; i <= waits; i++) begin
            bus.req_valid_i = 1'($urandom);
            bus.req_write_i = 1'($urandom);
            bus.req_addr_i  = AW'($urandom);
            bus.req_wdata_i = DW'($urandom);
            checks++;
            if (ctrl_command !== exp_cmd || bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wait_cycle %0d: got cmd=%0d ready=%b rsp_valid=%b expected cmd=%0d ready=0 rsp_valid=0",
                         i, ctrl_command, bus.req_ready_o, bus.rsp_valid_o, exp_cmd);
            end
            checks++;
            if (ctrl_addr !== addr || ctrl_wdata !== data) begin
                failures++;
                $display("[TB] FAIL ctrl_hold %0d: got addr=%h wdata=%h expected addr=%h wdata=%h",
                         i, ctrl_addr, ctrl_wdata, addr, data);
            end
            if (i == delay) begin
                if (is_write) ctrl_write_done = 1'b1;
                else begin
                    ctrl_read_valid = 1'b1;
                    ctrl_rdata      = rdata;
                end
            end else if (stray) begin
                if (is_write) ctrl_read_valid = 1'b1;
                else ctrl_write_done = 1'b1;
            end
            @(negedge clk);
            ctrl_write_done = 1'b0;
            ctrl_read_valid = 1'b0;
            ctrl_rdata      = DW'($urandom);
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_write_o !== is_write || bus.rsp_err_o !== timed_out ||
                bus.rsp_rdata_o !== exp_rdata || ctrl_command !== 2'd0 || bus.req_ready_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL response %0d: got valid=%b write=%b err=%b rdata=%h cmd=%0d ready=%b expected valid=1 write=%b err=%b rdata=%h cmd=0 ready=0",
                         h, bus.rsp_valid_o, bus.rsp_write_o, bus.rsp_err_o, bus.rsp_rdata_o,
                         ctrl_command, bus.req_ready_o, is_write, timed_out, exp_rdata);
            end
            bus.rsp_ready_i = (h == hold);
            ctrl_read_valid = 1'($urandom);
            ctrl_write_done = 1'($urandom);
            @(negedge clk);
            ctrl_read_valid = 1'b0;
            ctrl_write_done = 1'b0;
        end
        bus.rsp_ready_i = 1'b0;
        checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || ctrl_command !== 2'd0) begin
            failures++;
            $display("[TB] FAIL return_idle: got valid=%b ready=%b cmd=%0d expected valid=0 ready=1 cmd=0",
                     bus.rsp_valid_o, bus.req_ready_o, ctrl_command);
        end
        bus.req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        ctrl_rdata      = 16'h1357;
        ctrl_read_valid = 1'b1;
        ctrl_write_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ctrl_command !== 2'd0 || bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b0 ||
            bus.rsp_write_o !== 1'b0 || bus.rsp_rdata_o !== '0 || bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_state: got cmd=%0d valid=%b err=%b write=%b rdata=%h ready=%b expected 0 0 0 0 0000 1",
                     ctrl_command, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_write_o, bus.rsp_rdata_o, bus.req_ready_o);
        end
        rst             = 1'b0;
        bus.req_valid_i = 1'b0;
        ctrl_read_valid = 1'b0;
        ctrl_write_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 25'h000_1234, 16'hBEEF, 16'h0, 7, 0, 1'b0);
    endtask

    task automatic test_read_basic();
        run_txn(1'b0, 25'h1FF_FFFF, 16'h0F0F, 16'hA5A5, 10, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 25'h0AB_CDEF, 16'h1111, 16'h7777, T + 5, 0, 1'b0);
        run_txn(1'b1, 25'h155_5555, 16'h2222, 16'h0, T + 1, 1, 1'b0);
        run_txn(1'b0, 25'h0CC_0033, 16'h3333, 16'h9C9C, T, 0, 1'b0);
        run_txn(1'b1, 25'h000_0001, 16'h4444, 16'h0, T, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 25'h012_3456, 16'h5555, 16'hC3C3, 3, 5, 1'b0);
    endtask

    task automatic test_stray_pulse();
        run_txn(1'b0, 25'h076_5432, 16'h6666, 16'h5A5A, 6, 0, 1'b1);
        run_txn(1'b1, 25'h0FE_DCBA, 16'h8888, 16'h0, 4, 0, 1'b1);
    endtask

    task automatic test_reset_abort();
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = 25'h0A0_A0A0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ctrl_command !== 2'd0 || bus.rsp_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_drop: got cmd=%0d valid=%b expected cmd=0 valid=0", ctrl_command, bus.rsp_valid_o);
        end
        ctrl_read_valid = 1'b1;
        ctrl_rdata      = 16'hDEAD;
        @(negedge clk);
        ctrl_read_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.rsp_valid_o !== 1'b0 || ctrl_command !== 2'd0 || bus.req_ready_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL abort_late_pulse %0d: got valid=%b cmd=%0d ready=%b expected valid=0 cmd=0 ready=1",
                         i, bus.rsp_valid_o, ctrl_command, bus.req_ready_o);
            end
            @(negedge clk);
        end
    endtask

    // With requests always offered and responses always taken, a one-cycle
    // wait gives an accept every third cycle and never a RESP-cycle accept.
    task automatic test_back_to_back();
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = 25'h0000ABC;
        bus.req_wdata_i = 16'h1234;
        bus.rsp_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (bus.req_ready_o !== (c % 3 == 0) || bus.rsp_valid_o !== (c % 3 == 2)) begin
                failures++;
                $display("[TB] FAIL back_to_back cycle %0d: got ready=%b valid=%b expected ready=%b valid=%b",
                         c, bus.req_ready_o, bus.rsp_valid_o, (c % 3 == 0), (c % 3 == 2));
            end
            ctrl_write_done = (c % 3 == 1);
            @(negedge clk);
            ctrl_write_done = 1'b0;
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                    $urandom_range(T + 4, 1), $urandom_range(3, 0), 1'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        ctrl_read_valid = 1'b0;
        ctrl_write_done = 1'b0;
        ctrl_rdata      = '0;
        @(negedge clk);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_timeout();
        test_backpressure();
        test_stray_pulse();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
